arch_reg_file_mp: RTL and testbench

ARCH_REG_FILE_MP -- requirements
Module: arch_reg_file_mp

---
 rtl/arch_reg_file_mp.sv | 152 +++++++++++++++
 tb/tb_arch_reg_file_mp.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/arch_reg_file_mp.sv
// -----------------------------------------------------------------------------
// arch_reg_file_mp
//   Multi-ported architectural register file with multi-slot retire writes
//   and a sequential whole-file clear engine.
//
//   Register 0 is hardwired to zero: it is never written and always reads 0.
//   A pulse on clear_req starts a walk over registers 1..NUM_REG-1, zeroing
//   one register per cycle. Retires are refused (retire_ready low) while the
//   walk runs, and the producer is expected to hold them.
//
//   Optional feature macro: ARF_RETIRE_BYPASS_EN
//     defined   - reads see same-cycle accepted retire data combinationally
//     undefined - reads see stored contents only (new data next cycle)
//
// Ports
//   clk           in   clock, all state changes on posedge
//   rst_n         in   asynchronous active-low reset
//   rd_idx        in   NUM_READ packed read indices  (port p at [p*IDX_W +: IDX_W])
//   rd_data       out  NUM_READ packed read data     (port p at [p*REG_SIZE +: REG_SIZE])
//   retire_valid  in   per-slot retire strobe
//   retire_reg    in   per-slot destination index
//   retire_data   in   per-slot write data
//   retire_ready  out  retires accepted this cycle (low while clearing)
//   clear_req     in   single-cycle request to zero the whole file
//   clear_busy    out  high while the clear walk is running
// -----------------------------------------------------------------------------
module arch_reg_file_mp #(
    parameter int NUM_REG    = 32,
    parameter int REG_SIZE   = 32,
    parameter int NUM_READ   = 4,
    parameter int NUM_RETIRE = 2,
    localparam int IDX_W     = $clog2(NUM_REG)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_READ*IDX_W-1:0]      rd_idx,
    output logic [NUM_READ*REG_SIZE-1:0]   rd_data,
    input  logic [NUM_RETIRE-1:0]          retire_valid,
    input  logic [NUM_RETIRE*IDX_W-1:0]    retire_reg,
    input  logic [NUM_RETIRE*REG_SIZE-1:0] retire_data,
    output logic                           retire_ready,
    input  logic                           clear_req,
    output logic                           clear_busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    w_cnt_nxt;
    logic [REG_SIZE-1:0] r_regs [NUM_REG];
    logic [NUM_RETIRE-1:0] w_ret_acc;

    assign retire_ready = (r_state == S_IDLE);
    assign clear_busy   = (r_state == S_CLEAR);

    // A slot is accepted only when it targets a real register and the file
    // is not clearing; writes to r0 are silently discarded.
    always_comb begin
        w_ret_acc = '0;
        for (int s = 0; s < NUM_RETIRE; s++) begin
            w_ret_acc[s] = retire_valid[s]
                         && (retire_reg[s*IDX_W +: IDX_W] != '0)
                         && retire_ready;
        end
    end

    // Clear FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Clear FSM: next state. The walk starts at 1 because r0 is constant,
    // and stops after NUM_REG-1 so the counter never wraps mid-sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (clear_req) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = IDX_W'(1);
                end
            end
            S_CLEAR: begin
                if (r_cnt == IDX_W'(NUM_REG - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Storage. Retire slots are applied in ascending order so the
    // highest-numbered slot wins when several target the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == S_CLEAR) begin
            r_regs[r_cnt] <= '0;
        end else begin
            for (int s = 0; s < NUM_RETIRE; s++) begin
                if (w_ret_acc[s]) begin
                    r_regs[retire_reg[s*IDX_W +: IDX_W]] <= retire_data[s*REG_SIZE +: REG_SIZE];
                end
            end
        end
    end

    // Read ports
    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [IDX_W-1:0]    w_idx;
        logic [REG_SIZE-1:0] w_val;

        assign w_idx = rd_idx[p*IDX_W +: IDX_W];

        always_comb begin
            w_val = (w_idx == '0) ? '0 : r_regs[w_idx];
`ifdef ARF_RETIRE_BYPASS_EN
            // Later slots override earlier ones, matching the write priority.
            for (int s = 0; s < NUM_RETIRE; s++) begin
                if (w_ret_acc[s] && (retire_reg[s*IDX_W +: IDX_W] == w_idx)) begin
                    w_val = retire_data[s*REG_SIZE +: REG_SIZE];
                end
            end
`else
            // Stored contents only; a retire becomes visible next cycle.
`endif
        end

        assign rd_data[p*REG_SIZE +: REG_SIZE] = w_val;
    end

endmodule

// File: tb/tb_arch_reg_file_mp.sv
module tb_arch_reg_file_mp;

    localparam int NUM_REG    = 32;
    localparam int REG_SIZE   = 32;
    localparam int NUM_READ   = 4;
    localparam int NUM_RETIRE = 2;
    localparam int IDX_W      = 5;

    logic                           clk = 1'b0;
    logic                           rst_n = 1'b1;
    logic [NUM_READ*IDX_W-1:0]      rd_idx = '0;
    logic [NUM_READ*REG_SIZE-1:0]   rd_data;
    logic [NUM_RETIRE-1:0]          retire_valid = '0;
    logic [NUM_RETIRE*IDX_W-1:0]    retire_reg = '0;
    logic [NUM_RETIRE*REG_SIZE-1:0] retire_data = '0;
    logic                           retire_ready;
    logic                           clear_req = 1'b0;
    logic                           clear_busy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    arch_reg_file_mp #(
        .NUM_REG   (NUM_REG),
        .REG_SIZE  (REG_SIZE),
        .NUM_READ  (NUM_READ),
        .NUM_RETIRE(NUM_RETIRE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .retire_valid(retire_valid),
        .retire_reg  (retire_reg),
        .retire_data (retire_data),
        .retire_ready(retire_ready),
        .clear_req   (clear_req),
        .clear_busy  (clear_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] port(input int p);
        return rd_data[p*REG_SIZE +: REG_SIZE];
    endfunction

    task automatic set_port(input int p, input logic [IDX_W-1:0] r);
        rd_idx[p*IDX_W +: IDX_W] = r;
    endtask

    task automatic set_all(input logic [IDX_W-1:0] r);
        for (int p = 0; p < NUM_READ; p++) set_port(p, r);
    endtask

    task automatic ret(input int s, input logic [IDX_W-1:0] r, input logic [31:0] d);
        retire_valid[s]                  = 1'b1;
        retire_reg[s*IDX_W +: IDX_W]     = r;
        retire_data[s*REG_SIZE +: REG_SIZE] = d;
    endtask

    task automatic clr_ret();
        retire_valid = '0;
    endtask

    initial begin
        int n;

        // Reset state, asserted asynchronously
        #1 rst_n = 1'b0;
        #1;
        set_all(5);
        #1;
        push(32'd0); chk("rst_busy", 32'(clear_busy));
        push(32'd1); chk("rst_ready", 32'(retire_ready));
        push(32'd0); chk("rst_rd5", port(0));
        step();
        step();

        // Release reset and retire on the very first edge after it
        rst_n = 1'b1;
        ret(0, 5, 32'hDEADBEEF);
        step();
        clr_ret();
        set_all(5);
        #1;
        for (int p = 0; p < NUM_READ; p++) begin
            push(32'hDEADBEEF); chk($sformatf("r5_port%0d", p), port(p));
        end

        // Same-cycle collision: highest slot wins
        ret(0, 7, 32'h11);
        ret(1, 7, 32'h22);
        step();
        clr_ret();
        set_all(7);
        #1;
        push(32'h22); chk("r7_collide", port(0));

        // r0 writes are discarded; r9 written alongside
        ret(0, 0, 32'hFFFFFFFF);
        ret(1, 9, 32'h1234);
        step();
        clr_ret();
        set_all(0);
        #1;
        for (int p = 0; p < NUM_READ; p++) begin
            push(32'd0); chk($sformatf("r0_port%0d", p), port(p));
        end
        set_port(1, 9);
        #1;
        push(32'h1234); chk("r9_init", port(1));

        // Same-cycle read of a retiring register
        ret(1, 9, 32'hABCD);
        set_all(9);
        #1;
`ifdef ARF_RETIRE_BYPASS_EN
        push(32'hABCD); chk("r9_same_cycle", port(3));
`else
        push(32'h1234); chk("r9_same_cycle", port(3));
`endif
        step();
        clr_ret();
        #1;
        push(32'hABCD); chk("r9_next_cycle", port(3));

        // Fill r1..r31 with their index
        for (int i = 1; i < NUM_REG; i++) begin
            ret(0, IDX_W'(i), 32'(i));
            step();
        end
        clr_ret();
        set_port(0, 3);
        set_port(1, 31);
        #1;
        push(32'd3);  chk("fill_r3", port(0));
        push(32'd31); chk("fill_r31", port(1));

        // Clear pulse; a retire in the same cycle is still accepted
        clear_req = 1'b1;
        ret(0, 31, 32'h77);
        step();
        clear_req = 1'b0;
        clr_ret();
        #1;
        push(32'd1);  chk("clr_busy_start", 32'(clear_busy));
        push(32'd0);  chk("clr_ready_start", 32'(retire_ready));
        push(32'h77); chk("clr_r31_accepted", port(1));

        n = 0;
        while (clear_busy === 1'b1 && n < 40) begin
            n++;
            if (n == 5) begin
                set_port(0, 3);
                set_port(1, 31);
                ret(0, 3, 32'h55);
                #1;
                push(32'd0);  chk("mid_clear_r3", port(0));
                push(32'h77); chk("mid_clear_r31", port(1));
            end
            step();
            clr_ret();
        end
        push(32'd31); chk("clear_busy_cycles", 32'(n));
        push(32'd1);  chk("post_clear_ready", 32'(retire_ready));
        for (int r = 1; r < NUM_REG; r++) begin
            set_port(2, IDX_W'(r));
            #1;
            push(32'd0); chk($sformatf("post_clear_r%0d", r), port(2));
        end

        // Reset asserted in the middle of a clear walk
        ret(0, 2, 32'h22);
        ret(1, 20, 32'h99);
        step();
        clr_ret();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 9; i++) step();
        set_port(0, 20);
        set_port(1, 4);
        #1;
        push(32'h99); chk("pre_rst_r20", port(0));
        push(32'd1);  chk("pre_rst_busy", 32'(clear_busy));
        #1 rst_n = 1'b0;
        ret(0, 4, 32'h44);
        #1;
        push(32'd0); chk("rst_mid_busy", 32'(clear_busy));
        push(32'd1); chk("rst_mid_ready", 32'(retire_ready));
        push(32'd0); chk("rst_mid_r20", port(0));
        step();
        push(32'd0); chk("rst_no_write_r4", port(1));
        rst_n = 1'b1;
        clr_ret();
        step();
        push(32'd0); chk("rst_fsm_idle", 32'(clear_busy));
        ret(0, 4, 32'h44);
        step();
        clr_ret();
        #1;
        push(32'h44); chk("post_rst_r4", port(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
